// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - fetch-stage next-PC register with redirect priority, flush pulse and misalign halt
// Optional return-address stack is compiled in with PC_RAS_EN.
module pc_update_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              PC_STEP      = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            flag_jump,
    input  logic            flag_jalr,
    input  logic [XLEN-1:0] ID_PC,
    input  logic [XLEN-1:0] ID_imm,
    input  logic [XLEN-1:0] jalr_base,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] link,
    output logic            fetch_valid,
    output logic            flush,
    output logic            misalign_err
`ifdef PC_RAS_EN
    ,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] link_q, link_d;
    logic            flush_q, flush_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] jal_tgt;
    logic [XLEN-1:0] link_val;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            misalign;
    logic            accept;

    assign jalr_sum = jalr_base + ID_imm;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
    assign jal_tgt  = ID_PC + ID_imm;
    assign link_val = ID_PC + STEP;

    // EX-stage branch outranks the ID-stage jumps it is about to squash
    always_comb begin
        target = jal_tgt;
        if (branch_taken) begin
            target = branch_target;
        end else if (flag_jalr) begin
            target = jalr_tgt;
        end
    end

    assign redirect = branch_taken | flag_jalr | flag_jump;
    assign misalign = redirect & (|target[1:0]);
    assign accept   = (state_q == S_RUN) & redirect & ~misalign;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_d      = link_q;
        flush_d     = 1'b0;
        err_d       = err_q;
        fetch_valid = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                fetch_valid = ~stall;
                if (redirect) begin
                    flush_d = 1'b1;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d = target;
                        if (!branch_taken) begin
                            link_d = link_val;
                        end
                    end
                end else if (!stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            link_q  <= {XLEN{1'b0}};
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign PC           = pc_q;
    assign link         = link_q;
    assign flush        = flush_q;
    assign misalign_err = err_q;

`ifdef PC_RAS_EN
    localparam int             PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int             CW   = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0]  LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]  FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [PW-1:0]   ras_top_idx;
    logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
    logic            ras_push;
    logic            ras_pop;

    // ras_ptr_q is the next write slot; the top sits one below it, circularly
    assign ras_top_idx = (ras_ptr_q == {PW{1'b0}}) ? LAST : ras_ptr_q - PW'(1);
    assign ras_top     = ras_q[ras_top_idx];
    assign ras_empty   = (ras_cnt_q == {CW{1'b0}});

    assign ras_push = accept & ~branch_taken & ~flag_jalr & flag_jump;
    assign ras_pop  = accept & ~branch_taken & flag_jalr & ~ras_empty & (jalr_base == ras_top);

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push) begin
            ras_ptr_d = (ras_ptr_q == LAST) ? {PW{1'b0}} : ras_ptr_q + PW'(1);
            ras_cnt_d = (ras_cnt_q == FULL) ? ras_cnt_q : ras_cnt_q + CW'(1);
        end else if (ras_pop) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_ptr_q <= {PW{1'b0}};
            ras_cnt_q <= {CW{1'b0}};
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Entries need no reset: an empty count makes their contents irrelevant
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_q[ras_ptr_q] <= link_val;
        end
    end
`else
    logic unused_ras_cfg;
    assign unused_ras_cfg = (RAS_DEPTH > 0);
`endif

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Parametrised next-PC register for the fetch stage; it generalises the current PC update block.
- Additions over the current block:
  - stall hold and JALR redirect
  - registered flush pulse
  - misaligned-target trap with halt FSM
  - configurable width, reset vector and step
- Sits between EX/ID redirect sources and the instruction memory address port.

Parameters:
- XLEN, 32, datapath and PC width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  1  hold PC (hazard unit)
- branch_taken  in  1  EX-stage BGE/BLT resolved taken
- branch_target  in  XLEN  EX-stage branch target
- flag_jump  in  1  ID-stage JAL
- flag_jalr  in  1  ID-stage JALR
- ID_PC  in  XLEN  PC of the instruction in ID
- ID_imm  in  XLEN  sign-extended immediate of the instruction in ID
- jalr_base  in  XLEN  rs1 value for JALR
- PC  out  XLEN  current fetch address
- link  out  XLEN  return address of the last JAL/JALR
- fetch_valid  out  1  PC is a valid fetch this cycle
- flush  out  1  one-cycle pulse after any accepted redirect
- misalign_err  out  1  sticky misaligned-target trap

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - PC=RESET_VECTOR, link=0, flush=0, misalign_err=0, state=S_BOOT.
  - A reset asserted mid-redirect discards that redirect.
- FSM states: S_BOOT, S_RUN, S_HALT.
  - S_BOOT: first clock after reset release. PC holds, fetch_valid=0, all inputs ignored; next state S_RUN.
  - S_RUN: fetch_valid = ~stall.
  - S_HALT: PC, link and flush=0 frozen, fetch_valid=0; only reset exits.
- S_RUN next-PC, evaluated per clock, first match wins:
  1. branch_taken: target = branch_target.
  2. flag_jalr: target = (jalr_base + ID_imm) with bit0 cleared; link <= ID_PC + PC_STEP.
  3. flag_jump: target = ID_PC + ID_imm; link <= ID_PC + PC_STEP.
  4. stall: PC unchanged.
  5. Otherwise: PC <= PC + PC_STEP.
- Redirects (cases 1-3) override stall.
- Losing sources are ignored entirely: a lower-priority jump does not update link.
- Arithmetic is modulo 2^XLEN; PC wraps silently from all-ones.
- Misalignment: if a redirect target has bits[1:0] != 0:
  - PC is not updated, link is not updated;
  - misalign_err <= 1, state <= S_HALT, flush <= 1 for that one cycle.
- flush: registered; 1 in the cycle after an accepted redirect, else 0. Back-to-back redirects keep flush high.
- Latency: a redirect asserted at edge N is visible on PC after edge N (one cycle).

Optional Feature:
- Macro: PC_RAS_EN.
- With PC_RAS_EN defined:
  - RAS of RAS_DEPTH entries; extra outputs ras_top (XLEN) and ras_empty (1).
  - An accepted flag_jump pushes ID_PC+PC_STEP.
  - An accepted flag_jalr with jalr_base == ras_top and ~ras_empty pops.
  - Push when full overwrites the oldest entry (circular pointer, count saturates at RAS_DEPTH).
  - Pop when empty is a no-op.
  - Reset empties the stack.
- Without PC_RAS_EN: no stack logic and no extra ports.

Test Plan:
- Reset low then high, RESET_VECTOR=32'h100 -> PC=0x100, fetch_valid=0 for one cycle, then 0x104, 0x108 on following edges.
- stall=1 for 3 cycles at PC=0x108 -> PC stays 0x108, fetch_valid=0; release -> 0x10C.
- branch_taken=1 (target 0x200), flag_jump=1 and stall=1 in the same cycle -> PC=0x200, link unchanged, flush=1 next cycle.
- flag_jalr=1, jalr_base=0x301, ID_imm=4, ID_PC=0x40 -> PC=0x304, link=0x44.
- flag_jump=1, ID_PC=0x10, ID_imm=0x6 -> misalign_err=1, PC stays, S_HALT, fetch_valid=0 until reset.
- PC=0xFFFF_FFFC, no events -> PC=0x0000_0000 (wrap).
- Pulse reset low during a branch_taken cycle -> PC=RESET_VECTOR, flush=0.
